uart_prog: RTL and testbench
============================

Name: uart_prog

Overview:
Full-duplex UART core that supersedes the fixed-rate UART:
- runtime-programmable baud divisor
- selectable parity (none/even/odd)
- per-word receive error flags, a sticky overrun flag, and FIFO fill levels

It integrates the baud generator, RX/TX frame engines and two FIFOs in one module. It sits between a host bus/keyboard-mouse logic and the serial pins.

Parameters:
DBIT, 8, data bits per frame (5..9)
SB_TICK, 16, oversample ticks for the stop bit (16 = 1 stop, 24 = 1.5, 32 = 2)
DVSR_BIT, 11, width of the dvsr divisor input
FIFO_W, 4, FIFO address width; depth of each FIFO = 2**FIFO_W

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
dvsr  in  DVSR_BIT  baud divisor; tick period = dvsr+1 clk cycles (16 ticks per bit)
par_mode  in  2  00/11 = no parity, 01 = even, 10 = odd
rx  in  1  serial input, asynchronous to clk
rd_uart  in  1  pop the RX FIFO head
r_data  out  DBIT  RX FIFO head data
r_perr  out  1  parity error flag of the head word
r_ferr  out  1  framing error flag of the head word
rx_empty  out  1  RX FIFO empty
rx_level  out  FIFO_W+1  RX FIFO occupancy
rx_ovr  out  1  sticky overrun flag
clr_ovr  in  1  clears rx_ovr
wr_uart  in  1  push w_data into the TX FIFO
w_data  in  DBIT  TX data
tx_full  out  1  TX FIFO full
tx_level  out  FIFO_W+1  TX FIFO occupancy
tx_busy  out  1  TX engine is inside a frame
tx  out  1  serial output

Behaviour:
- Reset values: tx=1, tx_busy=0, rx_empty=1, tx_full=0, rx_level=0, tx_level=0, rx_ovr=0, r_data=0, r_perr=0, r_ferr=0.
- All state, both FSMs and both FIFOs return to idle/empty when reset asserts, including mid-frame.
- Baud counter:
  - counts 0..dvsr; emits a one-cycle tick and reloads 0 when count >= dvsr.
  - dvsr=0 gives a tick every clk.
  - a dvsr change takes effect on the next reload.
- RX input: passes through a 2-flop synchronizer, reset value 1.
- RX FSM states and transitions:
  - IDLE -> START on synchronized rx = 0.
  - START: after 7 ticks re-sample. If rx = 1, it is a false start -> IDLE. Otherwise go to DATA, tick count cleared.
  - DATA: sample every 16 ticks, LSB first, DBIT bits.
  - PARITY: one bit, entered only if parity is enabled.
  - STOP: sample after SB_TICK ticks, then return to IDLE.
  - par_mode is latched on IDLE->START.
  - perr = received parity mismatches the expected parity (even: XOR of data^parity = 0; odd: = 1); perr = 0 when parity is disabled.
  - ferr = stop sample is 0.
- RX completion:
  - At STOP completion, {ferr, perr, data} is pushed into the RX FIFO in the same cycle.
  - If the RX FIFO is full, the word is dropped and rx_ovr sets.
  - clr_ovr clears rx_ovr. If clr_ovr coincides with a drop, the flag stays 1.
- TX FSM states and transitions:
  - IDLE -> START when the TX FIFO is not empty, on the next tick. The head word and par_mode are latched at this point; tx_busy=1.
  - START: drive 0 for 16 ticks.
  - DATA: DBIT bits LSB first, 16 ticks each.
  - PARITY: one bit, only if parity is enabled.
  - STOP: drive 1 for SB_TICK ticks.
  - Then pop the TX FIFO (one cycle) and return to IDLE; tx_busy=0.
  - Back-to-back frames are allowed, with at most 1 tick of idle between them.
- FIFOs (both):
  - show-ahead: the head is visible whenever not empty; r_data/r_perr/r_ferr read 0 while rx_empty.
  - rd when empty and wr when full are ignored. Levels never wrap.
  - simultaneous rd+wr when full: both happen, level unchanged.
  - simultaneous rd+wr when empty: write only, no bypass.
  - full = level == 2**FIFO_W; empty = level == 0. Pointers wrap modulo depth.
  - Status outputs update the cycle after the causing edge.

Optional Feature:
UART_LOOPBACK_EN:
- When defined, adds input port loopback (1 bit).
- loopback=1: the RX synchronizer input is the internal tx signal and the external rx is ignored; the tx pin is held at 1.
- loopback=0, or macro not defined: normal pin operation. With the macro undefined the port does not exist.

Test Plan:
- dvsr=3, par_mode=00, write 0xA5 -> tx shows start 0, bits 1,0,1,0,0,1,0,1, stop 1; each bit 64 clk; tx_level 1->0 at end of stop; tx_busy high for 640 clk.
- Drive rx with 0x3C even parity at the same baud, par_mode=01 -> rx_empty falls, r_data=0x3C, r_perr=0, r_ferr=0; rd_uart -> rx_empty=1.
- Same frame with par_mode=10 -> r_perr=1. Frame with stop bit forced 0 -> r_ferr=1.
- Send 17 frames with FIFO_W=4 and no reads -> rx_level=16, rx_ovr=1, 17th word lost; clr_ovr -> rx_ovr=0.
- Write 16 words, assert wr_uart again while tx_full -> tx_level stays 16; simultaneous rd+wr when full -> level stays 16.
- Assert reset mid-TX data bit -> tx=1, tx_busy=0, tx_level=0 immediately. rx glitch low for 4 ticks -> no word pushed.

Source files
------------

// File: rtl/uart_prog.sv
// uart_prog: full-duplex UART core with programmable baud divisor, parity, RX error flags and RX/TX FIFOs
// Ports: clk, reset (async, active-low); dvsr (tick every dvsr+1 clk, 16 ticks per bit);
//   par_mode (01 even, 10 odd, 00/11 none); rx/tx serial pins;
//   RX side: rd_uart, r_data, r_perr, r_ferr, rx_empty, rx_level, rx_ovr, clr_ovr;
//   TX side: wr_uart, w_data, tx_full, tx_level, tx_busy.
// Optional: define UART_LOOPBACK_EN to add the loopback input (tx looped to rx, tx pin held at 1).
module uart_prog_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] w_data,
    output logic [W-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic [AW:0]  level
);
    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wp, rp;
    logic          do_rd, do_wr;
    assign empty  = level == '0;
    assign full   = level[AW];
    assign do_rd  = rd & ~empty;
    // a pop in the same cycle frees the slot, so a write when full still lands
    assign do_wr  = wr & (~full | do_rd);
    assign r_data = empty ? '0 : mem[rp];
    always_ff @(posedge clk)
        if (do_wr) mem[wp] <= w_data;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (do_wr) wp <= wp + AW'(1);
            if (do_rd) rp <= rp + AW'(1);
            level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
endmodule

module uart_prog #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR_BIT = 11,
    parameter int FIFO_W   = 4
) (
`ifdef UART_LOOPBACK_EN
    input  logic                loopback,
`endif
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic [1:0]          par_mode,
    input  logic                rx,
    input  logic                rd_uart,
    output logic [DBIT-1:0]     r_data,
    output logic                r_perr,
    output logic                r_ferr,
    output logic                rx_empty,
    output logic [FIFO_W:0]     rx_level,
    output logic                rx_ovr,
    input  logic                clr_ovr,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    output logic                tx_full,
    output logic [FIFO_W:0]     tx_level,
    output logic                tx_busy,
    output logic                tx
);
    localparam int SW = $clog2(SB_TICK);
    localparam int NW = $clog2(DBIT);
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
    logic [DVSR_BIT-1:0] b_cnt;
    logic                tick, rx_in, rx_m, rx_s, tx_q, tx_next;
    rx_state_t           r_st, r_st_n;
    logic [SW-1:0]       r_s, r_s_n;
    logic [NW-1:0]       r_n, r_n_n;
    logic [DBIT-1:0]     r_b, r_b_n;
    logic                r_p, r_p_n;
    logic [1:0]          r_par, r_par_n;
    logic                rx_done, rx_full, r_perr_n, r_ferr_n;
    tx_state_t           t_st, t_st_n;
    logic [SW-1:0]       t_s, t_s_n;
    logic [NW-1:0]       t_n, t_n_n;
    logic [DBIT-1:0]     t_b, t_b_n, tx_head;
    logic                t_p, t_p_n, t_pen, t_pen_n;
    logic                tx_done, tx_empty;
`ifdef UART_LOOPBACK_EN
    assign rx_in = loopback ? tx_q : rx;
    assign tx    = loopback | tx_q;
`else
    assign rx_in = rx;
    assign tx    = tx_q;
`endif
    assign tick     = b_cnt >= dvsr;
    assign tx_busy  = t_st != T_IDLE;
    assign r_ferr_n = ~rx_s;
    // odd parity (10) expects data^parity = 1, even (01) expects 0
    assign r_perr_n = ^r_par & ((^r_b ^ r_p) != r_par[1]);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            b_cnt  <= '0;
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            r_st   <= R_IDLE;
            r_s    <= '0;
            r_n    <= '0;
            r_b    <= '0;
            r_p    <= 1'b0;
            r_par  <= '0;
            t_st   <= T_IDLE;
            t_s    <= '0;
            t_n    <= '0;
            t_b    <= '0;
            t_p    <= 1'b0;
            t_pen  <= 1'b0;
            tx_q   <= 1'b1;
            rx_ovr <= 1'b0;
        end else begin
            b_cnt  <= tick ? '0 : b_cnt + DVSR_BIT'(1);
            rx_m   <= rx_in;
            rx_s   <= rx_m;
            r_st   <= r_st_n;
            r_s    <= r_s_n;
            r_n    <= r_n_n;
            r_b    <= r_b_n;
            r_p    <= r_p_n;
            r_par  <= r_par_n;
            t_st   <= t_st_n;
            t_s    <= t_s_n;
            t_n    <= t_n_n;
            t_b    <= t_b_n;
            t_p    <= t_p_n;
            t_pen  <= t_pen_n;
            tx_q   <= tx_next;
            // a drop in the same cycle as clr_ovr wins
            rx_ovr <= (rx_done & rx_full & ~rd_uart) ? 1'b1 : clr_ovr ? 1'b0 : rx_ovr;
        end
    always_comb begin
        r_st_n  = r_st;
        r_s_n   = r_s;
        r_n_n   = r_n;
        r_b_n   = r_b;
        r_p_n   = r_p;
        r_par_n = r_par;
        rx_done = 1'b0;
        case (r_st)
            R_IDLE: if (!rx_s) begin
                r_st_n  = R_START;
                r_s_n   = '0;
                r_par_n = par_mode;
            end
            R_START: if (tick) begin
                if (r_s == SW'(7)) begin
                    r_st_n = rx_s ? R_IDLE : R_DATA;
                    r_s_n  = '0;
                    r_n_n  = '0;
                end else r_s_n = r_s + SW'(1);
            end
            R_DATA: if (tick) begin
                if (r_s == SW'(15)) begin
                    r_s_n = '0;
                    r_b_n = {rx_s, r_b[DBIT-1:1]};
                    if (r_n == NW'(DBIT-1)) r_st_n = ^r_par ? R_PAR : R_STOP;
                    else r_n_n = r_n + NW'(1);
                end else r_s_n = r_s + SW'(1);
            end
            R_PAR: if (tick) begin
                if (r_s == SW'(15)) begin
                    r_s_n  = '0;
                    r_p_n  = rx_s;
                    r_st_n = R_STOP;
                end else r_s_n = r_s + SW'(1);
            end
            R_STOP: if (tick) begin
                if (r_s == SW'(SB_TICK-1)) begin
                    r_st_n  = R_IDLE;
                    rx_done = 1'b1;
                end else r_s_n = r_s + SW'(1);
            end
            default: r_st_n = R_IDLE;
        endcase
    end
    always_comb begin
        t_st_n  = t_st;
        t_s_n   = t_s;
        t_n_n   = t_n;
        t_b_n   = t_b;
        t_p_n   = t_p;
        t_pen_n = t_pen;
        tx_done = 1'b0;
        tx_next = 1'b1;
        case (t_st)
            T_IDLE: if (!tx_empty && tick) begin
                t_st_n  = T_START;
                t_s_n   = '0;
                t_b_n   = tx_head;
                t_pen_n = ^par_mode;
                // parity bit is fixed here since the data register shifts out
                t_p_n   = ^tx_head ^ par_mode[1];
            end
            T_START: begin
                tx_next = 1'b0;
                if (tick) begin
                    if (t_s == SW'(15)) begin
                        t_st_n = T_DATA;
                        t_s_n  = '0;
                        t_n_n  = '0;
                    end else t_s_n = t_s + SW'(1);
                end
            end
            T_DATA: begin
                tx_next = t_b[0];
                if (tick) begin
                    if (t_s == SW'(15)) begin
                        t_s_n = '0;
                        t_b_n = t_b >> 1;
                        if (t_n == NW'(DBIT-1)) t_st_n = t_pen ? T_PAR : T_STOP;
                        else t_n_n = t_n + NW'(1);
                    end else t_s_n = t_s + SW'(1);
                end
            end
            T_PAR: begin
                tx_next = t_p;
                if (tick) begin
                    if (t_s == SW'(15)) begin
                        t_s_n  = '0;
                        t_st_n = T_STOP;
                    end else t_s_n = t_s + SW'(1);
                end
            end
            T_STOP: if (tick) begin
                if (t_s == SW'(SB_TICK-1)) begin
                    t_st_n  = T_IDLE;
                    tx_done = 1'b1;
                end else t_s_n = t_s + SW'(1);
            end
            default: t_st_n = T_IDLE;
        endcase
    end
    uart_prog_fifo #(.W(DBIT+2), .AW(FIFO_W)) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (rx_done),
        .rd     (rd_uart),
        .w_data ({r_ferr_n, r_perr_n, r_b}),
        .r_data ({r_ferr, r_perr, r_data}),
        .empty  (rx_empty),
        .full   (rx_full),
        .level  (rx_level)
    );
    uart_prog_fifo #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr_uart),
        .rd     (tx_done),
        .w_data (w_data),
        .r_data (tx_head),
        .empty  (tx_empty),
        .full   (tx_full),
        .level  (tx_level)
    );
endmodule

// File: tb/tb_uart_prog.sv
// tb_uart_prog: directed self-checking bench for uart_prog (dvsr=3, 64 clk per bit)
module tb_uart_prog;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] dvsr = 11'd3;
    logic [1:0]  par_mode = 2'b00;
    logic        rx = 1'b1;
    logic        rd_uart = 1'b0;
    logic [7:0]  r_data;
    logic        r_perr, r_ferr, rx_empty, rx_ovr;
    logic [4:0]  rx_level, tx_level;
    logic        clr_ovr = 1'b0;
    logic        wr_uart = 1'b0;
    logic [7:0]  w_data = 8'h00;
    logic        tx_full, tx_busy, tx;
    int          n_vec = 0;
    int          n_err = 0;
    uart_prog dut (
        .clk      (clk),
        .reset    (reset),
        .dvsr     (dvsr),
        .par_mode (par_mode),
        .rx       (rx),
        .rd_uart  (rd_uart),
        .r_data   (r_data),
        .r_perr   (r_perr),
        .r_ferr   (r_ferr),
        .rx_empty (rx_empty),
        .rx_level (rx_level),
        .rx_ovr   (rx_ovr),
        .clr_ovr  (clr_ovr),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .tx_full  (tx_full),
        .tx_level (tx_level),
        .tx_busy  (tx_busy),
        .tx       (tx)
    );
    always #5 clk = ~clk;
    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic send_rx(input logic [7:0] d, input logic has_par, input logic pbit, input logic stop_ok);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (64) @(negedge clk);
        end
        if (has_par) begin
            rx = pbit;
            repeat (64) @(negedge clk);
        end
        rx = stop_ok;
        repeat (stop_ok ? 64 : 40) @(negedge clk);
        rx = 1'b1;
        repeat (64) @(negedge clk);
    endtask
    task automatic pop_rx();
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        logic [9:0] frame;
        int c;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_tx_full", tx_full, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_ovr", rx_ovr, 0);
        check("rst_r_data", r_data, 0);
        check("rst_r_perr", r_perr, 0);
        check("rst_r_ferr", r_ferr, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        // TX 0xA5, no parity: start, LSB-first data, stop
        frame = {1'b1, 8'hA5, 1'b0};
        w_data = 8'hA5;
        wr_uart = 1'b1;
        @(negedge clk);
        wr_uart = 1'b0;
        c = 0;
        while (!tx_busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("tx_start", tx_busy, 1);
        c = 0;
        while (tx_busy && c < 1000) begin
            if (c == 32) check("tx_level_busy", tx_level, 1);
            if (c >= 32 && (c - 32) % 64 == 0 && (c - 32) / 64 <= 9)
                check("tx_bit", tx, frame[(c - 32) / 64]);
            @(negedge clk);
            c++;
        end
        check("tx_busy_len", c, 640);
        check("tx_level_end", tx_level, 0);
        check("tx_idle", tx, 1);
        // RX 0x3C with even parity bit 0
        par_mode = 2'b01;
        send_rx(8'h3C, 1'b1, 1'b0, 1'b1);
        check("rx_even_empty", rx_empty, 0);
        check("rx_even_level", rx_level, 1);
        check("rx_even_data", r_data, 8'h3C);
        check("rx_even_perr", r_perr, 0);
        check("rx_even_ferr", r_ferr, 0);
        pop_rx();
        check("rx_even_pop", rx_empty, 1);
        // same frame judged as odd parity
        par_mode = 2'b10;
        send_rx(8'h3C, 1'b1, 1'b0, 1'b1);
        check("rx_odd_data", r_data, 8'h3C);
        check("rx_odd_perr", r_perr, 1);
        check("rx_odd_ferr", r_ferr, 0);
        pop_rx();
        // stop bit forced low
        par_mode = 2'b00;
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
        check("rx_ferr_data", r_data, 8'h5A);
        check("rx_ferr_perr", r_perr, 0);
        check("rx_ferr_ferr", r_ferr, 1);
        check("rx_ferr_level", rx_level, 1);
        pop_rx();
        check("rx_ferr_pop", rx_empty, 1);
        // 17 frames, no reads: 17th dropped, overrun sticky
        for (int i = 0; i < 17; i++) send_rx(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        check("ovr_level", rx_level, 16);
        check("ovr_flag", rx_ovr, 1);
        check("ovr_head", r_data, 8'h10);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        check("ovr_clr", rx_ovr, 0);
        for (int i = 0; i < 16; i++) begin
            check("ovr_drain", r_data, 8'h10 + 8'(i));
            pop_rx();
        end
        check("ovr_drained", rx_empty, 1);
        // fill TX FIFO, write while full, then write coinciding with the pop
        w_data = 8'hC3;
        wr_uart = 1'b1;
        repeat (16) @(negedge clk);
        check("txf_full", tx_full, 1);
        check("txf_level", tx_level, 16);
        @(negedge clk);
        check("txf_wr_full", tx_level, 16);
        c = 0;
        while (tx_busy && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("txf_rdwr_done", tx_busy, 0);
        check("txf_rdwr_level", tx_level, 16);
        wr_uart = 1'b0;
        // reset during a TX data bit
        c = 0;
        while (!tx_busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        repeat (100) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_level", tx_level, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        // 4-tick glitch on rx is a false start
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (1000) @(negedge clk);
        check("glitch_empty", rx_empty, 1);
        check("glitch_level", rx_level, 0);
        check("glitch_tx_idle", tx_busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
